adam_obi_rr_arbiter: RTL

- Shares one downstream OBI data port between NO_MSTS upstream OBI requesters, using round-robin arbitration.
- Typical use: core data port plus DIFT tag-check/debug master feeding a single adam_obi_to_axil converter.
- Tracks up to MAX_OUTST in-order outstanding transactions in an index FIFO and routes each response back to its issuer.
- Guarantees OBI address/request stability toward the downstream port.

---
 rtl/adam_obi_rr_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/adam_obi_rr_arbiter.sv
// Round-robin arbiter sharing one downstream OBI port among NO_MSTS requesters,
// with an in-order index FIFO routing responses back. Optional lock: ADAM_OBI_ARB_LOCK_EN.
module adam_obi_rr_arbiter #(
    parameter int NO_MSTS    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_OUTST  = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,

    input  logic [NO_MSTS-1:0]                     slv_req,
    output logic [NO_MSTS-1:0]                     slv_gnt,
    input  logic [NO_MSTS-1:0][ADDR_WIDTH-1:0]     slv_addr,
    input  logic [NO_MSTS-1:0]                     slv_we,
    input  logic [NO_MSTS-1:0][DATA_WIDTH/8-1:0]   slv_be,
    input  logic [NO_MSTS-1:0][DATA_WIDTH-1:0]     slv_wdata,
    output logic [NO_MSTS-1:0]                     slv_rvalid,
    input  logic [NO_MSTS-1:0]                     slv_rready,
    output logic [DATA_WIDTH-1:0]                  slv_rdata,
`ifdef ADAM_OBI_ARB_LOCK_EN
    input  logic [NO_MSTS-1:0]                     slv_lock,
`endif

    output logic                                   mst_req,
    input  logic                                   mst_gnt,
    output logic [ADDR_WIDTH-1:0]                  mst_addr,
    output logic                                   mst_we,
    output logic [DATA_WIDTH/8-1:0]                mst_be,
    output logic [DATA_WIDTH-1:0]                  mst_wdata,
    input  logic                                   mst_rvalid,
    output logic                                   mst_rready,
    input  logic [DATA_WIDTH-1:0]                  mst_rdata,

    output logic [$clog2(MAX_OUTST):0]             outst_cnt,
    output logic                                   err
);

    localparam int IDX_W = (NO_MSTS > 1) ? $clog2(NO_MSTS) : 1;
    localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CNT_W = $clog2(MAX_OUTST) + 1;

    typedef enum logic {OPEN, HOLD} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   hold_idx_q, hold_idx_d;
    logic [IDX_W-1:0]   sel, head;
    logic [IDX_W-1:0]   fifo_q [MAX_OUTST];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               fifo_full, fifo_empty, push, pop, err_q;
    logic               found;
    int                 scan_idx;
`ifdef ADAM_OBI_ARB_LOCK_EN
    logic               lock_q, lock_d;
    logic [IDX_W-1:0]   lock_idx_q, lock_idx_d;
`endif

    function automatic logic [IDX_W-1:0] inc_idx(input logic [IDX_W-1:0] v);
        return (v == IDX_W'(NO_MSTS - 1)) ? '0 : v + IDX_W'(1);
    endfunction

    function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] v);
        return (v == PTR_W'(MAX_OUTST - 1)) ? '0 : v + PTR_W'(1);
    endfunction

    // A lock owner or a held (issued but ungranted) request overrides the round-robin scan
    always_comb begin
        sel      = rr_ptr_q;
        found    = 1'b0;
        scan_idx = 0;
        for (int k = 0; k < NO_MSTS; k++) begin
            scan_idx = int'(rr_ptr_q) + k;
            if (scan_idx >= NO_MSTS) scan_idx = scan_idx - NO_MSTS;
            if (!found && slv_req[IDX_W'(scan_idx)]) begin
                sel   = IDX_W'(scan_idx);
                found = 1'b1;
            end
        end
        if (state_q == HOLD) sel = hold_idx_q;
`ifdef ADAM_OBI_ARB_LOCK_EN
        if (lock_q) sel = lock_idx_q;
`endif
    end

    assign fifo_full  = (cnt_q == CNT_W'(MAX_OUTST));
    assign fifo_empty = (cnt_q == '0);
    assign mst_req    = slv_req[sel] && !fifo_full;
    assign mst_addr   = slv_addr[sel];
    assign mst_we     = slv_we[sel];
    assign mst_be     = slv_be[sel];
    assign mst_wdata  = slv_wdata[sel];
    assign push       = mst_req && mst_gnt;

    assign head       = fifo_q[rd_ptr_q];
    assign mst_rready = !fifo_empty && slv_rready[head];
    assign pop        = mst_rvalid && mst_rready;
    assign slv_rdata  = mst_rdata;
    assign outst_cnt  = cnt_q;
    assign err        = err_q;

    always_comb begin
        slv_gnt         = '0;
        slv_gnt[sel]    = push;
        slv_rvalid      = '0;
        slv_rvalid[head] = mst_rvalid && !fifo_empty;
    end

    // Hold keeps the downstream address stable until the pending request is granted
    always_comb begin
        state_d    = state_q;
        hold_idx_d = hold_idx_q;
        rr_ptr_d   = rr_ptr_q;
`ifdef ADAM_OBI_ARB_LOCK_EN
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
`endif
        case (state_q)
            OPEN: if (mst_req && !mst_gnt) begin
                state_d    = HOLD;
                hold_idx_d = sel;
            end
            HOLD: if (push) state_d = OPEN;
            default: state_d = OPEN;
        endcase
`ifdef ADAM_OBI_ARB_LOCK_EN
        if (push) begin
            if (slv_lock[sel]) begin
                lock_d     = 1'b1;
                lock_idx_d = sel;
            end else begin
                lock_d     = 1'b0;
                rr_ptr_d   = inc_idx(sel);
            end
        end
`else
        if (push) rr_ptr_d = inc_idx(sel);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= OPEN;
            hold_idx_q <= '0;
            rr_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
`ifdef ADAM_OBI_ARB_LOCK_EN
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            hold_idx_q <= hold_idx_d;
            rr_ptr_q   <= rr_ptr_d;
`ifdef ADAM_OBI_ARB_LOCK_EN
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
`endif
            if (push) wr_ptr_q <= inc_ptr(wr_ptr_q);
            if (pop)  rd_ptr_q <= inc_ptr(rd_ptr_q);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
            if (mst_rvalid && fifo_empty) err_q <= 1'b1;
        end
    end

    // Index storage needs no reset; only entries between the pointers are ever read
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= sel;
    end

endmodule
